pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register for the five-stage CPU. It replaces the per-stage hand-written latches: one instance per stage boundary, with the payload packed as one vector. It adds correct stall/bubble semantics, a synchronous flush for branch/exception squash, a valid bit, and a held-status output. A build-time option adds stall/bubble performance counters.

Parameters:
DATA_W, 142, packed payload width (instruction, operator, operands, write enable/address/data).
STALL_W, 6, width of the stall vector from control.
UP_IDX, 2, index of this stage's upstream stall bit; the downstream bit is UP_IDX+1. Must satisfy UP_IDX+1 < STALL_W.
NOP_VALUE, 0, payload value loaded on reset, flush, bubble, and (if CLEAR_INVALID) invalid input.
CLEAR_INVALID, 1, 1 = load NOP_VALUE instead of in_payload when in_valid=0.
CNT_W, 16, performance counter width (only used with the optional feature).

Ports:
clock  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
stall  in  STALL_W  stall vector from control; 1 = stage stalled.
flush  in  1  squash this stage's contents.
in_valid  in  1  upstream slot holds a real instruction.
in_payload  in  DATA_W  upstream packed payload.
out_valid  out  1  registered valid.
out_payload  out  DATA_W  registered payload.
out_held  out  1  1 if the last update was a hold.
perf_stall_cycles  out  CNT_W  hold cycles with valid data (optional feature only).
perf_bubble_cycles  out  CNT_W  bubbles inserted (optional feature only).

Behaviour:
- up = stall[UP_IDX], dn = stall[UP_IDX+1]. One action per posedge, highest priority first:
  1 reset: out_valid=0, out_payload=NOP_VALUE, out_held=0, counters=0.
  2 flush: out_valid=0, out_payload=NOP_VALUE, out_held=0. Counters unchanged.
  3 up=1, dn=0 (BUBBLE): out_valid=0, out_payload=NOP_VALUE, out_held=0.
  4 up=0 (LOAD, regardless of dn): out_valid=in_valid. out_payload=in_payload, or NOP_VALUE when in_valid=0 and CLEAR_INVALID=1. out_held=0.
  5 up=1, dn=1 (HOLD): out_valid and out_payload unchanged; out_held=1.
- up=0 with dn=1 is an illegal control combination (downstream stall implies upstream stall). The block still performs LOAD; a simulation-only assertion flags it.
- Latency is exactly 1 cycle from input to output on LOAD. Outputs are pure flops; there is no combinational path from inputs to outputs.
- Flush during HOLD overrides the hold: contents are discarded in that same edge.
- Reset mid-hold clears everything, including out_held.
- Internal state is encoded as {out_valid, out_held}: EMPTY(00) -> FULL(10) on LOAD with valid. FULL -> HELD(11) on HOLD. HELD -> FULL on LOAD. Any state -> EMPTY on flush, bubble, or reset. HOLD while EMPTY gives 01 (empty held).

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: two CNT_W saturating counters, cleared only by reset.
  - perf_stall_cycles increments on each HOLD edge where out_valid=1.
  - perf_bubble_cycles increments on each BUBBLE edge.
  - Both stop at all-ones with no wrap.
- Undefined: the counter ports stay present but are tied to 0, and no counter flops exist.

Test Plan:
1. Reset 1 cycle -> out_valid=0, out_payload=0, out_held=0, counters=0. Then stall=0, in_valid=1, in_payload=0x1234 -> next edge out_payload=0x1234, out_valid=1.
2. Load 0xAAAA, then stall=6'b001100 (UP_IDX=2) for 3 cycles while in_payload=0xBBBB -> out_payload stays 0xAAAA, out_held=1, perf_stall_cycles=3. Release -> 0xBBBB.
3. stall=6'b000100 with in_payload=0xCCCC -> out_valid=0, out_payload=0, perf_bubble_cycles increments by 1.
4. Load 0xDDDD, then hold with flush=1 on the 2nd hold cycle -> out_valid=0, out_payload=0, out_held=0 on that edge.
5. in_valid=0 with in_payload=0xEEEE, stall=0: CLEAR_INVALID=1 gives out_payload=0; CLEAR_INVALID=0 gives 0xEEEE, in both cases with out_valid=0.
6. CNT_W=4: hold 20 valid cycles -> perf_stall_cycles saturates at 15. Reset asserted mid-hold -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/bubble/flush handling and a held-status flag.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int                DATA_W        = 142,
  parameter int                STALL_W       = 6,
  parameter int                UP_IDX        = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE     = '0,
  parameter bit                CLEAR_INVALID = 1'b1,
  parameter int                CNT_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic               out_held,
  output logic [CNT_W-1:0]   perf_stall_cycles,
  output logic [CNT_W-1:0]   perf_bubble_cycles
);

  // State bits are {out_valid, out_held}, so the outputs come straight off the flops.
  typedef enum logic [1:0] {
    EMPTY      = 2'b00,
    EMPTY_HELD = 2'b01,
    FULL       = 2'b10,
    HELD       = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [DATA_W-1:0] r_payload;
  logic [DATA_W-1:0] w_payloadNext;
  logic              w_up;
  logic              w_dn;
  logic              w_unusedStall;

  assign w_up          = stall[UP_IDX];
  assign w_dn          = stall[UP_IDX+1];
  assign w_unusedStall = ^stall;

  always_comb begin
    w_stateNext   = r_state;
    w_payloadNext = r_payload;
    if (flush) begin
      w_stateNext   = EMPTY;
      w_payloadNext = NOP_VALUE;
    end else if (w_up && !w_dn) begin
      w_stateNext   = EMPTY;
      w_payloadNext = NOP_VALUE;
    end else if (!w_up) begin
      w_stateNext = in_valid ? FULL : EMPTY;
      if (in_valid || !CLEAR_INVALID) begin
        w_payloadNext = in_payload;
      end else begin
        w_payloadNext = NOP_VALUE;
      end
    end else begin
      w_stateNext = r_state[1] ? HELD : EMPTY_HELD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_payload <= NOP_VALUE;
    end else begin
      r_state   <= w_stateNext;
      r_payload <= w_payloadNext;
    end
  end

  assign out_valid   = r_state[1];
  assign out_held    = r_state[0];
  assign out_payload = r_payload;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_bubbleCycles;
  logic             w_holdValid;
  logic             w_bubble;

  // Counters only see edges that actually performed a hold or bubble, so flush masks them.
  assign w_holdValid = !flush && w_up && w_dn && r_state[1];
  assign w_bubble    = !flush && w_up && !w_dn;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stallCycles  <= '0;
      r_bubbleCycles <= '0;
    end else begin
      if (w_holdValid && (r_stallCycles != {CNT_W{1'b1}})) begin
        r_stallCycles <= r_stallCycles + 1'b1;
      end
      if (w_bubble && (r_bubbleCycles != {CNT_W{1'b1}})) begin
        r_bubbleCycles <= r_bubbleCycles + 1'b1;
      end
    end
  end

  assign perf_stall_cycles  = r_stallCycles;
  assign perf_bubble_cycles = r_bubbleCycles;
`else
  assign perf_stall_cycles  = '0;
  assign perf_bubble_cycles = '0;
`endif

`ifndef SYNTHESIS
  // A downstream stall without an upstream stall means control is broken; the stage still loads.
  always @(posedge clock) begin
    if (!reset && !flush) begin
      assert (w_up || !w_dn);
    end
  end
`endif

endmodule
